// File: rtl/buf_pkg.sv
// Shared definitions for the push/pop storage buffer and its arbiter:
// mode and opcode encodings plus the arbiter FSM state type.
package buf_pkg;

  localparam logic [1:0] MODE_FIFO   = 2'd0;
  localparam logic [1:0] MODE_LIFO   = 2'd1;

  localparam logic [1:0] OP_NIMIC    = 2'd0;
  localparam logic [1:0] OP_PUSH     = 2'd1;
  localparam logic [1:0] OP_POP      = 2'd2;
  localparam logic [1:0] OP_PUSH_POP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode == MODE_FIFO) || (mode == MODE_LIFO);
  endfunction

endpackage

// File: rtl/buffer_arbiter_rr.sv
// Round-robin pick: first valid requester at or after ptr (wrapping),
// returned as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    int cand;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (valid[cand]) begin
        idx = ID_W'(cand);
        any = 1'b1;
      end
    end
    if (any) begin
      grant = NUM_REQ'(1) << idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// Shares one FIFO/LIFO buffer between NUM_REQ requesters: round-robin
// grant, full/empty pre-check, opcode sequencing and response return.
module buffer_arbiter
  import buf_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                cfg_mode,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_pop,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                buf_mode,
  output logic [1:0]                buf_opcode,
  output logic [DATA_W-1:0]         buf_din,
  input  logic [DATA_W-1:0]         buf_dout,
  input  logic                      buf_full,
  input  logic                      buf_empty,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [1:0]          active_mode_q, active_mode_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                pop_q, pop_d;
  logic [DATA_W-1:0]   buf_din_q, buf_din_d;
  logic [1:0]          buf_opcode_q, buf_opcode_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     idx_s;
  logic                any_s;
  logic                legal_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  assign legal_s = req_pop[idx_s] ? !buf_empty : !buf_full;

  // Next-state and next-output computation for the IDLE/ISSUE/RESP sequence.
  always_comb begin
    state_d       = state_q;
    active_mode_d = active_mode_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    pop_d         = pop_q;
    buf_din_d     = buf_din_q;
    buf_opcode_d  = OP_NIMIC;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_id_d      = rsp_id_q;
    req_ready     = '0;
    case (state_q)
      ST_IDLE: begin
        // A pending mode switch takes the cycle; grants resume next cycle.
        if (mode_legal(cfg_mode) && (cfg_mode != active_mode_q) && buf_empty) begin
          active_mode_d = cfg_mode;
        end else if (any_s) begin
          req_ready = grant_s;
          id_d      = idx_s;
          pop_d     = req_pop[idx_s];
          buf_din_d = req_data[idx_s*DATA_W +: DATA_W];
          if (idx_s == ID_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = idx_s + ID_W'(1);
          end
          if (legal_s) begin
            state_d      = ST_ISSUE;
            buf_opcode_d = req_pop[idx_s] ? OP_POP : OP_PUSH;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_id_d    = idx_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      active_mode_q <= MODE_FIFO;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      pop_q         <= 1'b0;
      buf_din_q     <= '0;
      buf_opcode_q  <= OP_NIMIC;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      active_mode_q <= active_mode_d;
      rr_ptr_q      <= rr_ptr_d;
      id_q          <= id_d;
      pop_q         <= pop_d;
      buf_din_q     <= buf_din_d;
      buf_opcode_q  <= buf_opcode_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  // The buffer's read register settles on the edge that ends ISSUE,
  // so pop data is forwarded straight through during RESP.
  assign rsp_data   = (rsp_valid_q && pop_q && !rsp_err_q) ? buf_dout : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_id     = rsp_id_q;
  assign buf_mode   = active_mode_q;
  assign buf_opcode = buf_opcode_q;
  assign buf_din    = buf_din_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
